// File: rtl/cache_pkg.sv
// Shared definitions for the read-only cache and its fill controller.
package cache_pkg;

    localparam int SIZE_BLOCK_DEF = 32;
    localparam int BIT_TOTAL_DEF  = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } fill_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler for cache_ro: looks up the cache, fetches misses over Avalon-MM,
// fills the cache and returns the word, with hit/miss statistics.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int SIZE_BLOCK = SIZE_BLOCK_DEF,
    parameter int BIT_TOTAL  = BIT_TOTAL_DEF,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BIT_TOTAL-1:0]  req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [SIZE_BLOCK-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  c_en,
    output logic                  c_wrt,
    output logic [BIT_TOTAL-1:0]  c_addr,
    output logic [SIZE_BLOCK-1:0] c_wdata,
    input  logic [SIZE_BLOCK-1:0] c_rdata,
    input  logic                  c_success,
    output logic                  m_read,
    output logic [BIT_TOTAL-1:0]  m_addr,
    input  logic                  m_waitrequest,
    input  logic [SIZE_BLOCK-1:0] m_readdata,
    input  logic                  m_readdatavalid,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    fill_state_t           state_q, state_d;
    logic [BIT_TOTAL-1:0]  addr_q, addr_d;
    logic [SIZE_BLOCK-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  c_en_q, c_en_d;
    logic                  c_wrt_q, c_wrt_d;
    logic                  m_read_q, m_read_d;
    logic                  hit_inc, miss_inc;

    // Outputs are computed for the state being entered so they are all flops.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        c_en_d      = 1'b0;
        c_wrt_d     = 1'b0;
        m_read_d    = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    addr_d      = req_addr;
                    err_d       = 1'b0;
                    req_ready_d = 1'b0;
                    c_en_d      = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: state_d = CHECK;
            CHECK: begin
                if (c_success) begin
                    data_d      = c_rdata;
                    hit_inc     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    miss_inc = 1'b1;
                    tmo_d    = '0;
                    m_read_d = 1'b1;
                    state_d  = MEM_REQ;
                end
            end
            MEM_REQ, MEM_WAIT: begin
                // Data arriving in the last budgeted cycle still wins over the timeout.
                if (state_q == MEM_WAIT && m_readdatavalid) begin
                    data_d  = m_readdata;
                    c_en_d  = 1'b1;
                    c_wrt_d = 1'b1;
                    state_d = FILL;
                end else if (tmo_q == TMO_LAST) begin
                    data_d      = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (state_q == MEM_REQ) begin
                        if (m_waitrequest) begin
                            m_read_d = 1'b1;
                        end else begin
                            state_d = MEM_WAIT;
                        end
                    end
                end
            end
            FILL: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            c_en_q      <= 1'b0;
            c_wrt_q     <= 1'b0;
            m_read_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            c_en_q      <= c_en_d;
            c_wrt_q     <= c_wrt_d;
            m_read_q    <= m_read_d;
        end
    end

    sat_counter #(.W(32)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(32)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign c_en      = c_en_q;
    assign c_wrt     = c_wrt_q;
    assign c_addr    = addr_q;
    assign c_wdata   = data_q;
    assign m_read    = m_read_q;
    assign m_addr    = addr_q;

endmodule
